// File: rtl/alarm_responder.sv
// Alarm responder: debounced trigger, timed entry delay, timed siren.
// Ports: clk, rst_n (sync), arm, alarm_req, disarm -> siren, pending, state_o, event_cnt.
module alarm_responder #(
  parameter int DEB_CYC   = 4,
  parameter int ENTRY_CYC = 16,
  parameter int SIREN_CYC = 64,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             arm,
  input  logic             alarm_req,
  input  logic             disarm,
  output logic             siren,
  output logic             pending,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] event_cnt
);

  localparam int TMAX = (ENTRY_CYC > SIREN_CYC) ? ENTRY_CYC : SIREN_CYC;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int DW   = $clog2(DEB_CYC + 1);

  typedef enum logic [1:0] {
    DISARMED = 2'd0,
    ARMED    = 2'd1,
    PENDING  = 2'd2,
    ALARM    = 2'd3
  } state_t;

  state_t          state;
  logic [TW-1:0]   tmr;
  logic [DW-1:0]   deb;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= DISARMED;
      tmr       <= '0;
      deb       <= '0;
      event_cnt <= '0;
    end else begin
      unique case (state)
        DISARMED: begin
          tmr <= '0;
          deb <= '0;
          if (arm) state <= ARMED;
        end
        ARMED: begin
          tmr <= '0;
          if (!arm) begin
            state <= DISARMED;
            deb   <= '0;
          end else if (alarm_req) begin
            if (deb == DW'(DEB_CYC - 1)) begin
              state <= PENDING;
              deb   <= '0;
            end else begin
              deb <= deb + DW'(1);
            end
          end else begin
            deb <= '0;
          end
        end
        PENDING: begin
          deb <= '0;
          if (disarm) begin
            state <= DISARMED;
            tmr   <= '0;
          end else if (tmr == TW'(ENTRY_CYC - 1)) begin
            state <= ALARM;
            tmr   <= '0;
            if (event_cnt != '1)
              event_cnt <= event_cnt + CNT_W'(1);
          end else begin
            tmr <= tmr + TW'(1);
          end
        end
        ALARM: begin
          deb <= '0;
          if (disarm) begin
            state <= DISARMED;
            tmr   <= '0;
          end else if (tmr == TW'(SIREN_CYC - 1)) begin
            state <= arm ? ARMED : DISARMED;
            tmr   <= '0;
          end else begin
            tmr <= tmr + TW'(1);
          end
        end
        default: begin
          state <= DISARMED;
          tmr   <= '0;
          deb   <= '0;
        end
      endcase
    end
  end

  // Outputs decode only the state register.
  assign state_o = state;
  assign siren   = (state == ALARM);
  assign pending = (state == PENDING);

endmodule

// File: tb/tb_alarm_responder.sv
// Scoreboard bench for alarm_responder: default instance plus a
// CNT_W=2 instance driven in parallel to exercise saturation.
module tb_alarm_responder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       arm;
  logic       alarm_req;
  logic       disarm;
  logic       siren, pending;
  logic [1:0] state_o;
  logic [7:0] event_cnt;
  logic       siren2, pending2;
  logic [1:0] state2;
  logic [1:0] event_cnt2;

  always #5 clk = ~clk;

  alarm_responder dut (
    .clk(clk), .rst_n(rst_n), .arm(arm),
    .alarm_req(alarm_req), .disarm(disarm),
    .siren(siren), .pending(pending),
    .state_o(state_o), .event_cnt(event_cnt)
  );

  alarm_responder #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .arm(arm),
    .alarm_req(alarm_req), .disarm(disarm),
    .siren(siren2), .pending(pending2),
    .state_o(state2), .event_cnt(event_cnt2)
  );

  typedef struct {
    int         cyc;
    string      nm;
    logic [1:0] st;
    logic [7:0] cnt;
    logic [1:0] cnt2;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   exp_cnt = 0;
  int   exp_cnt2 = 0;

  always @(posedge clk) cyc++;

  // Monitor: every negedge, compare all expectations due this cycle.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (e.cyc < cyc) begin
        errors++;
        $display("FAIL %s: stale expectation cyc %0d at cyc %0d",
                 e.nm, e.cyc, cyc);
      end else if (state_o !== e.st || siren !== (e.st == 2'd3) ||
                   pending !== (e.st == 2'd2) || event_cnt !== e.cnt ||
                   state2 !== e.st || siren2 !== (e.st == 2'd3) ||
                   pending2 !== (e.st == 2'd2) || event_cnt2 !== e.cnt2) begin
        errors++;
        $display("FAIL %s cyc %0d: got st=%0d sir=%b pend=%b cnt=%0d st2=%0d cnt2=%0d, want st=%0d cnt=%0d cnt2=%0d",
                 e.nm, cyc, state_o, siren, pending, event_cnt,
                 state2, event_cnt2, e.st, e.cnt, e.cnt2);
      end
    end
  end

  task automatic tick(input string nm, input logic [1:0] st);
    exp_t e;
    e.cyc  = cyc + 1;
    e.nm   = nm;
    e.st   = st;
    e.cnt  = 8'(exp_cnt);
    e.cnt2 = 2'(exp_cnt2);
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic bump();
    if (exp_cnt < 255) exp_cnt++;
    if (exp_cnt2 < 3) exp_cnt2++;
  endtask

  // From ARMED with alarm_req rising: 3 debounce edges, 4th enters PENDING.
  task automatic to_pending();
    alarm_req = 1'b1;
    repeat (3) tick("debounce", 2'd1);
    tick("pend_entry", 2'd2);
  endtask

  // From just-entered PENDING: 15 more PENDING cycles, then ALARM.
  task automatic to_alarm();
    repeat (15) tick("entry_hold", 2'd2);
    bump();
    tick("siren_on", 2'd3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; arm = 1'b0; alarm_req = 1'b0; disarm = 1'b0;
    @(posedge clk); #1;
    tick("reset", 2'd0);
    rst_n = 1'b1;
    disarm = 1'b1;
    tick("idle_disarm_ignored", 2'd0);
    disarm = 1'b0;
    arm = 1'b1;
    tick("arm", 2'd1);
    disarm = 1'b1;
    tick("armed_disarm_ignored", 2'd1);
    disarm = 1'b0;

    // Debounce reject twice; counter must clear between pulses.
    for (int k = 0; k < 2; k++) begin
      alarm_req = 1'b1;
      repeat (3) tick("deb_reject", 2'd1);
      alarm_req = 1'b0;
      tick("deb_gap", 2'd1);
    end

    // arm drop beats a trigger on the same edge.
    alarm_req = 1'b1;
    repeat (3) tick("deb_pre", 2'd1);
    arm = 1'b0;
    tick("arm_priority", 2'd0);
    alarm_req = 1'b0;
    arm = 1'b1;
    tick("rearm", 2'd1);

    // Full alarm, alarm_req held throughout; returns to ARMED.
    to_pending();
    to_alarm();
    repeat (63) tick("siren_hold", 2'd3);
    tick("siren_exit_armed", 2'd1);

    // alarm_req still high: debounce restarts, then entry disarm at cycle 10.
    repeat (3) tick("deb_restart", 2'd1);
    tick("pend_again", 2'd2);
    repeat (9) tick("entry_hold", 2'd2);
    disarm = 1'b1;
    tick("entry_disarm", 2'd0);
    disarm = 1'b0;
    alarm_req = 1'b0;

    // Disarm on last siren cycle overrides expiry even with arm=1.
    tick("rearm2", 2'd1);
    to_pending();
    alarm_req = 1'b0;
    to_alarm();
    repeat (63) tick("siren_hold", 2'd3);
    disarm = 1'b1;
    tick("last_cycle_disarm", 2'd0);
    disarm = 1'b0;

    // arm dropped during PENDING/ALARM is ignored until the exit edge.
    tick("rearm3", 2'd1);
    to_pending();
    alarm_req = 1'b0;
    arm = 1'b0;
    to_alarm();
    repeat (63) tick("siren_hold", 2'd3);
    tick("exit_disarmed", 2'd0);

    // Fourth alarm saturates the 2-bit counter.
    arm = 1'b1;
    tick("rearm4", 2'd1);
    to_pending();
    alarm_req = 1'b0;
    to_alarm();
    repeat (63) tick("siren_hold", 2'd3);
    tick("exit_armed4", 2'd1);

    // Fifth alarm, reset mid-ALARM.
    to_pending();
    alarm_req = 1'b0;
    to_alarm();
    repeat (10) tick("siren_hold", 2'd3);
    rst_n = 1'b0;
    exp_cnt = 0;
    exp_cnt2 = 0;
    tick("reset_mid_alarm", 2'd0);
    rst_n = 1'b1;
    arm = 1'b0;
    tick("post_reset", 2'd0);

    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
